matrix_operand_bank: RTL
========================

Name: matrix_operand_bank

Overview:
- Parametrised operand store for the N x N matrix-multiply datapath.
- Serially loads a weight matrix W and an input matrix X, both row-major, one element per clock.
- After both are full, streams W one column and X one row per beat to the systolic array through a valid/ready handshake.
- Each operand clears separately, so W can be kept while a new X is loaded.

Parameters:
- N, 3, matrix dimension (N >= 2)
- DW, 4, element width in bits
- CW, $clog2(N*N+1), load counter width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear_w  in  1  synchronous clear of W memory and W counter
- clear_x  in  1  synchronous clear of X memory and X counter
- data_in  in  DW  serial element input
- load_w  in  1  write data_in to W[w_cnt] this cycle
- load_x  in  1  write data_in to X[x_cnt] this cycle
- w_full  out  1  W holds N*N elements
- x_full  out  1  X holds N*N elements
- start  out  1  one-cycle pulse when both memories become full
- unload_go  in  1  begin one unload pass (sampled in READY only)
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_step  out  $clog2(N)  index k of current beat
- data_outw  out  N*DW  lane i = W[i*N+k]
- data_outx  out  N*DW  lane i = X[k*N+i]
- done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (rst_n low, asynchronous):
  - all memory words, counters and outputs go to 0
  - FSM goes to LOAD
- Memory writes:
  - Memory words are reset and cleared entries only.
  - A write occurs when load_* is high and the counter is below N*N; the counter then increments.
  - load_* while full is ignored: no write, no wrap.
  - load_w and load_x together: W is written, X is ignored that cycle.
  - Loads are ignored in UNLOAD.
- Fill flags: w_full = (w_cnt == N*N), x_full = (x_cnt == N*N), both registered.
- start: high the cycle after the write that makes both full (the last write may be to either memory).
- Clears:
  - clear_w / clear_x zero their memory and counter next edge and take priority over a same-cycle load to that memory.
  - Either clear in READY or UNLOAD aborts to LOAD; out_valid drops next cycle and done does not pulse.
- FSM:
  - LOAD -> READY when w_full & x_full.
  - READY -> UNLOAD on unload_go; k = 0.
  - UNLOAD: out_valid = 1. The beat transfers on out_valid & out_ready, then k increments. A beat that is not transferred holds data_out*/out_step stable.
  - Transfer of beat k = N-1 -> READY with a done pulse. Data is retained, so a later unload_go repeats the pass.
  - unload_go outside READY is ignored.
- Latency:
  - first beat valid 1 cycle after unload_go
  - a full pass takes N beats with zero stall cycles
- Output registers: registered. When out_valid = 0, data_outw, data_outx and out_step read 0.

Optional Feature:
- Macro: MATRIX_OPERAND_BANK_SKEW_EN.
- Defined:
  - Outputs are diagonally skewed for systolic feeding: lane i is delayed i beats, and the missing slots are zero-filled.
  - A pass lasts 2N-1 beats; out_step counts 0..2N-2 (width $clog2(2N-1)).
  - Skew registers advance only on transfer, so stalls stay aligned.
  - done pulses after beat 2N-2.
- Undefined: unskewed N-beat pass as above.

Decomposition:
- Package matrix_bank_pkg: FSM state enum (LOAD, READY, UNLOAD), function lane_idx_w(i,k)=i*N+k, lane_idx_x(i,k)=k*N+i.
- One sub-module: skew_delay_line (per-lane DW-wide shift register of depth i with enable), instantiated only under MATRIX_OPERAND_BANK_SKEW_EN.

Test Plan:
- N=3, DW=4; load W=1..9, then X=10..15,0,1,2 -> w_full after 9th W write; start pulses once after 9th X write; a 10th load_x is ignored and x_cnt stays 9.
- unload_go, out_ready=1 -> beats:
  - k=0: w lanes {1,4,7}, x lanes {10,11,12}
  - k=1: w lanes {2,5,8}, x lanes {13,14,15}
  - k=2: w lanes {3,6,9}, x lanes {0,1,2}
  - done pulses after k=2 is accepted.
- out_ready low for 3 cycles at k=1 -> outputs are held at k=1 values and out_valid stays 1; pass completes in 3 transfers.
- load_w and load_x high together with data 5 -> only W is written; then clear_x mid-UNLOAD -> out_valid=0 next cycle, no done, x_full=0, W retained and w_full=1.
- rst_n pulsed low asynchronously mid-pass -> all outputs and counters are 0 immediately; FSM is in LOAD.
- SKEW_EN build, same data -> beat 0 w lanes {1,0,0}, beat 1 {2,4,0}, beat 4 {0,0,9}; 5 beats total, then done.

Source files
------------

// File: rtl/matrix_operand_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_bank_pkg
//  Description : Shared definitions for the matrix operand bank: controller
//                state encoding and the lane-to-memory index mapping used when
//                streaming W by column and X by row.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_bank_pkg;

  // Controller states: filling memories, both full and idle, streaming a pass.
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    READY  = 2'd1,
    UNLOAD = 2'd2
  } bank_state_e;

  // W is row-major; beat k presents column k, so lane i is W[i][k].
  function automatic int lane_idx_w(input int n, input int i, input int k);
    return i * n + k;
  endfunction

  // X is row-major; beat k presents row k, so lane i is X[k][i].
  function automatic int lane_idx_x(input int n, input int i, input int k);
    return k * n + i;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_operand_bank_skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay_line
//  Description : DW-wide shift register of DEPTH stages with shift enable and
//                synchronous zeroing. dout is the oldest stage, i.e. the value
//                presented on din DEPTH enabled shifts ago.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                en    - shift din into the line
//                clr   - zero every stage (wins over en)
//                din   - element entering the line
//                dout  - element leaving the line
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
  parameter int DW    = 4,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) r_stage[j] <= '0;
    end else if (clr) begin
      for (int j = 0; j < DEPTH; j++) r_stage[j] <= '0;
    end else if (en) begin
      r_stage[0] <= din;
      for (int j = 1; j < DEPTH; j++) r_stage[j] <= r_stage[j-1];
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/matrix_operand_bank.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_operand_bank
//  Description : Operand store for an N x N matrix-multiply array. Serially
//                loads row-major W and X one element per clock, then streams
//                one W column and one X row per beat over valid/ready.
//                Optional macro MATRIX_OPERAND_BANK_SKEW_EN diagonally skews
//                the lanes (lane i delayed i beats, zero filled, 2N-1 beats).
//  Ports       : clk, rst_n          - clock, async active-low reset
//                clear_w, clear_x    - synchronous clear of one memory
//                data_in, load_w/x   - serial element write
//                w_full, x_full      - memory holds N*N elements
//                start               - pulse when both memories become full
//                unload_go           - begin a pass (honoured in READY only)
//                out_valid/out_ready - beat handshake
//                out_step            - beat index k
//                data_outw/data_outx - lane i = W[i*N+k] / X[k*N+i]
//                done                - pulse after the last beat transfers
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_operand_bank
  import matrix_bank_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 4,
  parameter int CW = $clog2(N*N+1),
`ifdef MATRIX_OPERAND_BANK_SKEW_EN
  localparam int STEPS = 2*N-1,
`else
  localparam int STEPS = N,
`endif
  localparam int SW = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_w,
  input  logic          clear_x,
  input  logic [DW-1:0] data_in,
  input  logic          load_w,
  input  logic          load_x,
  output logic          w_full,
  output logic          x_full,
  output logic          start,
  input  logic          unload_go,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_step,
  output logic [N*DW-1:0] data_outw,
  output logic [N*DW-1:0] data_outx,
  output logic          done
);

  localparam int NN = N * N;
  localparam logic [CW-1:0] c_nn   = CW'(NN);
  localparam logic [SW-1:0] c_last = SW'(STEPS-1);

  bank_state_e r_state, w_state_nxt;

  logic [DW-1:0]   r_mem_w [NN];
  logic [DW-1:0]   r_mem_x [NN];
  logic [CW-1:0]   r_w_cnt, r_x_cnt, w_w_cnt_nxt, w_x_cnt_nxt;
  logic            r_w_full, r_x_full, r_start, r_done;
  logic            w_we_w, w_we_x, w_w_full_nxt, w_x_full_nxt;
  logic [SW-1:0]   r_k, w_k_nxt;
  logic            w_adv, w_done_nxt, w_xfer, w_clr_any;
  logic [N*DW-1:0] r_data_w, r_data_x;
  logic [DW-1:0]   w_src_w [N];
  logic [DW-1:0]   w_src_x [N];
  logic [DW-1:0]   w_lane_w [N];
  logic [DW-1:0]   w_lane_x [N];

  // --------------------------------------------------------------------------
  // Serial load. W wins when both loads are requested; a full memory ignores
  // further loads, and nothing is written while a pass is streaming.
  // --------------------------------------------------------------------------
  assign w_we_w = load_w & ~clear_w & (r_state != UNLOAD) & (r_w_cnt != c_nn);
  assign w_we_x = load_x & ~load_w & ~clear_x & (r_state != UNLOAD) &
                  (r_x_cnt != c_nn);

  always_comb begin
    w_w_cnt_nxt = r_w_cnt;
    w_x_cnt_nxt = r_x_cnt;
    if (clear_w)     w_w_cnt_nxt = '0;
    else if (w_we_w) w_w_cnt_nxt = r_w_cnt + CW'(1);
    if (clear_x)     w_x_cnt_nxt = '0;
    else if (w_we_x) w_x_cnt_nxt = r_x_cnt + CW'(1);
  end

  assign w_w_full_nxt = (w_w_cnt_nxt == c_nn);
  assign w_x_full_nxt = (w_x_cnt_nxt == c_nn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NN; e++) begin
        r_mem_w[e] <= '0;
        r_mem_x[e] <= '0;
      end
    end else begin
      for (int e = 0; e < NN; e++) begin
        if (clear_w)                            r_mem_w[e] <= '0;
        else if (w_we_w && r_w_cnt == CW'(e))   r_mem_w[e] <= data_in;
        if (clear_x)                            r_mem_x[e] <= '0;
        else if (w_we_x && r_x_cnt == CW'(e))   r_mem_x[e] <= data_in;
      end
    end
  end

  // Flags track the counters; start fires on the rising edge of "both full".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_cnt  <= '0;
      r_x_cnt  <= '0;
      r_w_full <= 1'b0;
      r_x_full <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_w_cnt  <= w_w_cnt_nxt;
      r_x_cnt  <= w_x_cnt_nxt;
      r_w_full <= w_w_full_nxt;
      r_x_full <= w_x_full_nxt;
      r_start  <= w_w_full_nxt & w_x_full_nxt & ~(r_w_full & r_x_full);
    end
  end

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  assign out_valid = (r_state == UNLOAD);
  assign w_xfer    = out_valid & out_ready;
  assign w_clr_any = clear_w | clear_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  // w_adv marks an edge that presents a new beat (pass start or transfer of a
  // non-final beat); output and skew registers move only on those edges.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_adv       = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      LOAD: begin
        if (!w_clr_any && r_w_full && r_x_full) w_state_nxt = READY;
      end
      READY: begin
        if (w_clr_any) begin
          w_state_nxt = LOAD;
        end else if (unload_go) begin
          w_state_nxt = UNLOAD;
          w_k_nxt     = '0;
          w_adv       = 1'b1;
        end
      end
      UNLOAD: begin
        if (w_clr_any) begin
          w_state_nxt = LOAD;
          w_k_nxt     = '0;
        end else if (w_xfer) begin
          if (r_k == c_last) begin
            w_state_nxt = READY;
            w_k_nxt     = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_k_nxt = r_k + SW'(1);
            w_adv   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_k_nxt     = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Lane sources for beat w_k_nxt. Beats at or beyond N (skewed tail) have no
  // source column/row and read zero.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_src_w[i] = '0;
      w_src_x[i] = '0;
      for (int kk = 0; kk < N; kk++) begin
        if (w_k_nxt == SW'(kk)) begin
          w_src_w[i] = r_mem_w[lane_idx_w(N, i, kk)];
          w_src_x[i] = r_mem_x[lane_idx_x(N, i, kk)];
        end
      end
    end
  end

`ifdef MATRIX_OPERAND_BANK_SKEW_EN
  // Lane i sees the source from i beats ago. The lines are held at zero
  // outside a pass so the leading diagonal is zero filled.
  logic w_dl_clr;
  assign w_dl_clr    = (w_state_nxt != UNLOAD);
  assign w_lane_w[0] = w_src_w[0];
  assign w_lane_x[0] = w_src_x[0];

  for (genvar gi = 1; gi < N; gi++) begin : g_skew
    skew_delay_line #(.DW(DW), .DEPTH(gi)) u_dl_w (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_adv),
      .clr   (w_dl_clr),
      .din   (w_src_w[gi]),
      .dout  (w_lane_w[gi])
    );
    skew_delay_line #(.DW(DW), .DEPTH(gi)) u_dl_x (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_adv),
      .clr   (w_dl_clr),
      .din   (w_src_x[gi]),
      .dout  (w_lane_x[gi])
    );
  end
`else
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign w_lane_w[gi] = w_src_w[gi];
    assign w_lane_x[gi] = w_src_x[gi];
  end
`endif

  // --------------------------------------------------------------------------
  // Output registers: zero whenever no beat is valid, held during a stall.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k      <= '0;
      r_done   <= 1'b0;
      r_data_w <= '0;
      r_data_x <= '0;
    end else begin
      r_k    <= w_k_nxt;
      r_done <= w_done_nxt;
      if (w_state_nxt != UNLOAD) begin
        r_data_w <= '0;
        r_data_x <= '0;
      end else if (w_adv) begin
        for (int i = 0; i < N; i++) begin
          r_data_w[i*DW +: DW] <= w_lane_w[i];
          r_data_x[i*DW +: DW] <= w_lane_x[i];
        end
      end
    end
  end

  assign w_full    = r_w_full;
  assign x_full    = r_x_full;
  assign start     = r_start;
  assign done      = r_done;
  assign out_step  = r_k;
  assign data_outw = r_data_w;
  assign data_outx = r_data_x;

endmodule
`default_nettype wire
